// File: rtl/conv_maxpool.sv
// conv_maxpool: non-overlapping 2x2 max pooling of the conv engine's 8x10 result map into a 4x5 map.
// Build macro POOL_RELU_EN: when defined, pooled values are clamped at zero before storage.
module conv_maxpool #(
  parameter int IN_R = 8,
  parameter int IN_C = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_pool,
  output logic [6:0]         in_rd_addr,
  input  logic signed [31:0] in_rd_data,
  input  logic [4:0]         pool_rd_addr,
  output logic signed [31:0] pool_rd_data,
  output logic [31:0]        cycles,
  output logic               done
);

  localparam int OUT_R = IN_R / 2;
  localparam int OUT_C = IN_C / 2;
  localparam int N_OUT = OUT_R * OUT_C;

  localparam logic [6:0] IN_C_W  = 7'(IN_C);
  localparam logic [2:0] LAST_R  = 3'(OUT_R - 1);
  localparam logic [2:0] LAST_C  = 3'(OUT_C - 1);
  localparam logic [4:0] OUT_C_W = 5'(OUT_C);
  localparam logic [4:0] N_OUT_W = 5'(N_OUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    if (b > a) begin
      return b;
    end else begin
      return a;
    end
  endfunction

  function automatic logic signed [31:0] pool_clamp(input logic signed [31:0] v);
`ifdef POOL_RELU_EN
    if (v < 32'sd0) begin
      return 32'sd0;
    end else begin
      return v;
    end
`else
    return v;
`endif
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         win_r_q, win_r_d;
  logic [2:0]         win_c_q, win_c_d;
  logic [1:0]         k_q, k_d;
  logic signed [31:0] max_q, max_d;
  logic [31:0]        cycles_q, cycles_d;
  logic               done_q, done_d;
  logic signed [31:0] pool_mem_q [N_OUT];
  logic signed [31:0] pool_mem_d [N_OUT];

  logic               pass_end_s;
  logic [6:0]         row_s;
  logic [6:0]         col_s;
  logic [6:0]         rd_addr_s;
  logic [4:0]         wr_idx_s;
  logic signed [31:0] cand_s;

  // Window geometry: element k selects the row/column offset inside the current 2x2 window.
  assign row_s      = {3'd0, win_r_q, 1'b0} + {6'd0, k_q[1]};
  assign col_s      = {3'd0, win_c_q, 1'b0} + {6'd0, k_q[0]};
  assign rd_addr_s  = row_s * IN_C_W + col_s;
  assign wr_idx_s   = {2'd0, win_r_q} * OUT_C_W + {2'd0, win_c_q};
  assign cand_s     = smax(max_q, in_rd_data);
  assign pass_end_s = (win_r_q == LAST_R) && (win_c_q == LAST_C) && (k_q == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_pool) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (pass_end_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (!start_pool) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // done is registered so it tracks S_DONE exactly, dropping on the edge that returns to idle.
  always_comb begin
    done_d = (state_d == S_DONE);
    if (state_q == S_RUN) begin
      in_rd_addr = rd_addr_s;
    end else begin
      in_rd_addr = 7'd0;
    end
  end

  always_comb begin
    win_r_d    = win_r_q;
    win_c_d    = win_c_q;
    k_d        = k_q;
    max_d      = max_q;
    cycles_d   = cycles_q;
    pool_mem_d = pool_mem_q;
    if ((state_q == S_IDLE) && start_pool) begin
      win_r_d  = 3'd0;
      win_c_d  = 3'd0;
      k_d      = 2'd0;
      cycles_d = 32'd0;
    end else if (state_q == S_RUN) begin
      cycles_d = cycles_q + 32'd1;
      k_d      = k_q + 2'd1;
      case (k_q)
        2'd0: max_d = in_rd_data;
        2'd3: begin
          pool_mem_d[wr_idx_s] = pool_clamp(cand_s);
          if (win_c_q == LAST_C) begin
            win_c_d = 3'd0;
            if (win_r_q == LAST_R) begin
              win_r_d = 3'd0;
            end else begin
              win_r_d = win_r_q + 3'd1;
            end
          end else begin
            win_c_d = win_c_q + 3'd1;
          end
        end
        default: max_d = cand_s;
      endcase
    end else begin
      cycles_d = cycles_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_r_q  <= 3'd0;
      win_c_q  <= 3'd0;
      k_q      <= 2'd0;
      max_q    <= 32'sd0;
      cycles_q <= 32'd0;
      done_q   <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        pool_mem_q[i] <= 32'sd0;
      end
    end else begin
      win_r_q    <= win_r_d;
      win_c_q    <= win_c_d;
      k_q        <= k_d;
      max_q      <= max_d;
      cycles_q   <= cycles_d;
      done_q     <= done_d;
      pool_mem_q <= pool_mem_d;
    end
  end

  // Read port has no backing storage beyond the pooled map, so higher addresses return 0.
  always_comb begin
    if (pool_rd_addr < N_OUT_W) begin
      pool_rd_data = pool_mem_q[pool_rd_addr];
    end else begin
      pool_rd_data = 32'sd0;
    end
  end

  assign cycles = cycles_q;
  assign done   = done_q;

endmodule
